// File: rtl/fetch_sequencer.sv
// Program-counter and run-state sequencer for the accumulator processor.
// Drives the instruction ROM address and owns the Start/Done handshake with the harness.
// Optional build macro FETCH_CYCLE_COUNT_EN adds the CycleCount output (RUN-cycle counter).
module fetch_sequencer #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned OFF_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Branch,
   input  logic             BrCond,
   input  logic [OFF_W-1:0] BrOffset,
   output logic [PC_W-1:0]  PC,
   output logic             Run,
`ifdef FETCH_CYCLE_COUNT_EN
   output logic             Done,
   output logic [31:0]      CycleCount
`else
   output logic             Done
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StHalted} state_t;

   localparam logic [PC_W-1:0] PcOne = PC_W'(1);

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic            run_q;
   logic            done_q;
   logic [PC_W-1:0] off_ext;

   // Sign-extend the branch offset to PC width; the sum below then wraps modulo 2^PC_W.
   always_comb begin
      off_ext = PC_W'($signed(BrOffset));
   end

   // Sequencer FSM: state, PC and the registered Run/Done flags update together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // PC is held at 0 so the first executed instruction is address 0.
               pc_q <= '0;
               if (!Start) begin
                  state_q <= StRun;
                  run_q   <= 1'b1;
               end
            end
            StRun: begin
               if (Start) begin
                  state_q <= StIdle;
                  pc_q    <= '0;
                  run_q   <= 1'b0;
               end else if (Halt) begin
                  // Halt outranks a simultaneous taken branch; PC stays on the halt instruction.
                  state_q <= StHalted;
                  run_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else if (Branch && BrCond) begin
                  pc_q <= pc_q + off_ext;
               end else begin
                  pc_q <= pc_q + PcOne;
               end
            end
            StHalted: begin
               if (Start) begin
                  state_q <= StIdle;
                  pc_q    <= '0;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               pc_q    <= '0;
               run_q   <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign PC   = pc_q;
   assign Run  = run_q;
   assign Done = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [31:0] cyc_cnt_q;

   // Count edges spent in RUN (including the exit edge); hold while HALTED; clear in IDLE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cyc_cnt_q <= '0;
      end else if (state_q == StIdle) begin
         cyc_cnt_q <= '0;
      end else if (state_q == StRun && cyc_cnt_q != 32'hFFFF_FFFF) begin
         cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
   end

   // Masking by IDLE state makes the count read 0 from the edge that enters IDLE.
   assign CycleCount = (state_q == StIdle) ? 32'd0 : cyc_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (PC_W=10, OFF_W=8).
module tb_fetch_sequencer;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Halt;
   logic       Branch;
   logic       BrCond;
   logic [7:0] BrOffset;
   logic [9:0] PC;
   logic       Run;
   logic       Done;
`ifdef FETCH_CYCLE_COUNT_EN
   logic [31:0] CycleCount;
`endif

   int checks = 0;
   int errors = 0;

   fetch_sequencer #(
      .PC_W (10),
      .OFF_W(8)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Halt      (Halt),
      .Branch    (Branch),
      .BrCond    (BrCond),
      .BrOffset  (BrOffset),
      .PC        (PC),
      .Run       (Run),
`ifdef FETCH_CYCLE_COUNT_EN
      .Done      (Done),
      .CycleCount(CycleCount)
`else
      .Done      (Done)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [9:0] pc, input logic run,
                              input logic done);
      check({tag, ".pc"}, {22'd0, PC}, {22'd0, pc});
      check({tag, ".run"}, {31'd0, Run}, {31'd0, run});
      check({tag, ".done"}, {31'd0, Done}, {31'd0, done});
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b1; Halt = 1'b0; Branch = 1'b0; BrCond = 1'b0; BrOffset = 8'h00;
      #1;
      check_state("reset", 10'h000, 1'b0, 1'b0);
      tick();
      Reset = 1'b0;

      // Start held high: stay IDLE with PC 0.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("idle_hold", 10'h000, 1'b0, 1'b0);
      end

      // Start falls: first edge enters RUN at PC 0, then 1,2,3.
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_state("run_seq", 10'(i), 1'b1, 1'b0);
      end
      for (int i = 4; i <= 16; i++) tick();
      check("pc_at_10", {22'd0, PC}, 32'h010);

      // Taken backward branch 0x010 + (-4) = 0x00C.
      Branch = 1'b1; BrCond = 1'b1; BrOffset = 8'hFC;
      tick();
      check("br_taken_back", {22'd0, PC}, 32'h00C);
      Branch = 1'b0; BrCond = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pc_back_10", {22'd0, PC}, 32'h010);

      // Branch with condition false falls through.
      Branch = 1'b1; BrCond = 1'b0; BrOffset = 8'hFC;
      tick();
      check("br_not_taken", {22'd0, PC}, 32'h011);

      // 0x011 + (-18) wraps to 0x3FF, then sequential wrap to 0x000.
      BrCond = 1'b1; BrOffset = 8'hEE;
      tick();
      check("br_to_3ff", {22'd0, PC}, 32'h3FF);
      Branch = 1'b0; BrCond = 1'b0;
      tick();
      check("wrap_3ff", {22'd0, PC}, 32'h000);

      // 0x000 + (-2) = 0x3FE, then 0x3FE + 5 wraps to 0x003.
      Branch = 1'b1; BrCond = 1'b1; BrOffset = 8'hFE;
      tick();
      check("br_to_3fe", {22'd0, PC}, 32'h3FE);
      BrOffset = 8'h05;
      tick();
      check("br_wrap_fwd", {22'd0, PC}, 32'h003);

      // Zero offset taken spins on the same PC.
      BrOffset = 8'h00;
      tick();
      check("spin1", {22'd0, PC}, 32'h003);
      tick();
      check("spin2", {22'd0, PC}, 32'h003);

      // 0x003 + 0x1D = 0x020.
      BrOffset = 8'h1D;
      tick();
      check("br_to_20", {22'd0, PC}, 32'h020);

      // Halt beats a simultaneous taken branch.
      Halt = 1'b1;
      tick();
      check_state("halt", 10'h020, 1'b0, 1'b1);
      Halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("halted_hold", 10'h020, 1'b0, 1'b1);
      end
      Branch = 1'b0; BrCond = 1'b0;

      // Start from HALTED returns to IDLE.
      Start = 1'b1;
      tick();
      check_state("halt_to_idle", 10'h000, 1'b0, 1'b0);

      // Synchronous abort from RUN.
      Start = 1'b0;
      tick();
      check_state("rerun", 10'h000, 1'b1, 1'b0);
      tick();
      check("rerun_pc1", {22'd0, PC}, 32'h001);
      Start = 1'b1;
      tick();
      check_state("abort", 10'h000, 1'b0, 1'b0);

      // Run to 0x055, then assert Reset between edges.
      Start = 1'b0;
      tick();
      Branch = 1'b1; BrCond = 1'b1; BrOffset = 8'h55;
      tick();
      check_state("at_55", 10'h055, 1'b1, 1'b0);
      Branch = 1'b0; BrCond = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      check_state("async_reset", 10'h000, 1'b0, 1'b0);
      tick();
      check_state("reset_held", 10'h000, 1'b0, 1'b0);
      Start = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
      check_state("post_reset_idle", 10'h000, 1'b0, 1'b0);

`ifdef FETCH_CYCLE_COUNT_EN
      check("cc_idle", CycleCount, 32'd0);
      Start = 1'b0;
      tick();
      check("cc_enter_run", CycleCount, 32'd0);
      for (int i = 0; i < 7; i++) tick();
      check("cc_run7", CycleCount, 32'd7);
      Halt = 1'b1;
      tick();
      Halt = 1'b0;
      check("cc_halt", CycleCount, 32'd8);
      for (int i = 0; i < 10; i++) tick();
      check("cc_frozen", CycleCount, 32'd8);
      check("cc_done", {31'd0, Done}, 32'd1);
      Start = 1'b1;
      tick();
      check("cc_cleared", CycleCount, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and run-state sequencer for the accumulator processor.
- Sits directly upstream of the instruction decoder: it drives the instruction ROM address that produces TypeBit/OP/operand bits.
- Consumes the decoder's Branch and Halt outputs to choose the next PC.
- Owns the Start/Done handshake with the test harness.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
OFF_W, 8, branch offset width (low instruction bits when TypeBit=1), two's complement.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  harness start level; high = hold/reload, falling to low = begin execution.
Halt  input  1  decoder halt for the current instruction.
Branch  input  1  decoder branch for the current instruction.
BrCond  input  1  branch condition, accumulator bit 0 (1 = take).
BrOffset  input  OFF_W  signed PC-relative offset from the current instruction.
PC  output  PC_W  instruction ROM address of the current instruction.
Run  output  1  high while executing; decoder outputs are meaningful only when Run=1.
Done  output  1  high while halted.

Behaviour:
- Interface (already decided): one clock, Clk; reset Reset is asynchronous and active-high.
- States: IDLE, RUN, HALTED, encoded in a registered state variable.
- Reset (async, any state, including mid-run): state=IDLE, PC=0, Run=0, Done=0. Reset has priority over all other inputs.
- Run and Done are decoded from registered state only, so they change only on clock edges:
  - Run = (state==RUN).
  - Done = (state==HALTED).
- IDLE:
  - Start=1: stay IDLE, PC=0.
  - Start=0: next state RUN, PC stays 0, so the first executed instruction is address 0.
  - Halt, Branch and BrCond are ignored.
- RUN: one instruction per cycle. Priority, highest first:
  1. Start=1: go to IDLE, PC<=0 (synchronous abort).
  2. Halt=1: go to HALTED, PC holds its value.
  3. Branch=1 and BrCond=1: PC <= PC + sign_extend(BrOffset). Addition is modulo 2^PC_W.
  4. Otherwise: PC <= PC + 1, modulo 2^PC_W (0x3FF wraps to 0x000).
- Branch=1 with BrCond=0 behaves as rule 4 (fall through).
- Offset 0 with the branch taken reloads the same PC (spin loop); this is legal.
- Halt=1 and Branch=1 in the same cycle: Halt wins.
- HALTED:
  - PC frozen, Done=1.
  - Start=1: go to IDLE, PC=0, Done drops on that edge.
  - All other inputs ignored.
- Latency: the PC update is visible one cycle after the decoder inputs are sampled. There is no bubble and no pipelining.
- Sign extension copies BrOffset[OFF_W-1] into the upper PC_W-OFF_W bits. OFF_W must be <= PC_W.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- When defined:
  - Adds output CycleCount [31:0]: number of clock edges spent in RUN.
  - Cleared to 0 on Reset and whenever the state is IDLE.
  - Increments on each edge where the state is RUN (including the edge leaving RUN).
  - Frozen while HALTED; saturates at 0xFFFFFFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then Start=1 for 3 cycles, then Start=0 -> PC=0, Run=0 while Start=1; Run=1 on the first edge after Start falls; PC then reads 0,1,2,3 on successive cycles.
- In RUN at PC=0x010: Branch=1, BrCond=1, BrOffset=0xFC -> next PC=0x00C. Branch=1, BrCond=0 -> next PC=0x011.
- PC=0x3FF with no branch -> next PC=0x000. PC=0x3FE with BrOffset=0x05 taken -> PC=0x003.
- Halt=1 together with Branch=1, BrCond=1 at PC=0x020 -> PC stays 0x020, Done=1 and Run=0 next cycle and held. Later Start=1 -> PC=0, Done=0, state IDLE.
- Assert Reset asynchronously mid-run at PC=0x055 (between edges) -> PC=0, Run=0, Done=0 immediately, without waiting for Clk.
- With FETCH_CYCLE_COUNT_EN: Start falls, run 7 cycles, then Halt -> CycleCount=8 and stays 8 for 10 further cycles. Start=1 -> CycleCount=0.
